// File: rtl/packet_generator.sv
// Synthetic AXI-Stream packet source with run control, idle gaps and transmit counters.
// Define PKTGEN_PRBS_EN to replace the counter payload with a 32-bit Galois LFSR.
module packet_generator #(
  parameter int TDATA_WIDTH = 512,
  parameter int TKEEP_WIDTH = TDATA_WIDTH / 8
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   start,
  input  logic                   stop,
  input  logic [15:0]            cfg_packet_bytes,
  input  logic [31:0]            cfg_num_packets,
  input  logic [15:0]            cfg_gap_cycles,
  output logic [TDATA_WIDTH-1:0] out_stream_TDATA,
  output logic [TKEEP_WIDTH-1:0] out_stream_TKEEP,
  output logic                   out_stream_TVALID,
  input  logic                   out_stream_TREADY,
  output logic                   out_stream_TLAST,
  output logic                   busy,
  output logic                   done,
  output logic [63:0]            sent_flit_count,
  output logic [63:0]            sent_packet_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP, ST_DONE} state_e;

  localparam logic [15:0] KEEP_W = 16'(TKEEP_WIDTH);

  state_e                 state_q, state_d;
  logic [31:0]            num_q, num_d;
  logic [15:0]            gap_q, gap_d;
  logic [15:0]            last_idx_q, last_idx_d;
  logic [15:0]            rem_q, rem_d;
  logic [15:0]            flit_idx_q, flit_idx_d;
  logic [31:0]            seq_q, seq_d;
  logic [15:0]            gap_cnt_q, gap_cnt_d;
  logic                   stop_req_q, stop_req_d;
  logic [63:0]            flit_cnt_q, flit_cnt_d;
  logic [63:0]            pkt_cnt_q, pkt_cnt_d;
  logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [TKEEP_WIDTH-1:0] tkeep_q, tkeep_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   launch, accept;

  assign launch = (state_q == ST_IDLE) && start && (cfg_packet_bytes != 16'd0);
  assign accept = (state_q == ST_SEND) && out_stream_TREADY;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d    = state_q;
    num_d      = num_q;
    gap_d      = gap_q;
    last_idx_d = last_idx_q;
    rem_d      = rem_q;
    flit_idx_d = flit_idx_q;
    seq_d      = seq_q;
    gap_cnt_d  = gap_cnt_q;
    stop_req_d = stop_req_q;
    flit_cnt_d = flit_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d    = ST_SEND;
          num_d      = cfg_num_packets;
          gap_d      = cfg_gap_cycles;
          last_idx_d = (cfg_packet_bytes - 16'd1) / KEEP_W;
          rem_d      = cfg_packet_bytes % KEEP_W;
          flit_idx_d = '0;
          seq_d      = '0;
          gap_cnt_d  = '0;
          stop_req_d = stop;
          flit_cnt_d = '0;
          pkt_cnt_d  = '0;
        end
      end
      ST_SEND: begin
        // A stop request is remembered so it ends the run at the next packet boundary.
        stop_req_d = stop_req_q | stop;
        if (accept) begin
          flit_cnt_d = flit_cnt_q + 64'd1;
          if (flit_idx_q == last_idx_q) begin
            pkt_cnt_d  = pkt_cnt_q + 64'd1;
            seq_d      = seq_q + 32'd1;
            flit_idx_d = '0;
            gap_cnt_d  = '0;
            if (((num_q != 32'd0) && (pkt_cnt_d == {32'd0, num_q})) || stop_req_d)
              state_d = ST_DONE;
            else if (gap_q != 16'd0)
              state_d = ST_GAP;
          end else begin
            flit_idx_d = flit_idx_q + 16'd1;
          end
        end
      end
      ST_GAP: begin
        stop_req_d = stop_req_q | stop;
        if (stop_req_d)
          state_d = ST_DONE;
        else if (gap_cnt_q == gap_q - 16'd1)
          state_d = ST_SEND;
        else
          gap_cnt_d = gap_cnt_q + 16'd1;
      end
      ST_DONE: begin
        state_d    = ST_IDLE;
        stop_req_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef PKTGEN_PRBS_EN
  localparam int LANES32 = (TDATA_WIDTH + 31) / 32;
  logic [31:0]           lfsr_q, lfsr_d;
  logic [LANES32*32-1:0] payload_wide;

  always_comb begin
    lfsr_d = lfsr_q;
    if (launch)
      lfsr_d = 32'hFFFF_FFFF;
    else if (accept)
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
    payload_wide = {LANES32{lfsr_d}};
  end

  always_ff @(posedge clk) begin
    if (!aresetn) lfsr_q <= '0;
    else          lfsr_q <= lfsr_d;
  end
`else
  localparam int LANES64 = (TDATA_WIDTH + 63) / 64;
  logic [LANES64*64-1:0] payload_wide;

  assign payload_wide = {LANES64{seq_d, 16'd0, flit_idx_d}};
`endif

  // Outputs are computed from next-state values so they can be registered without lag.
  always_comb begin
    tvalid_d = (state_d == ST_SEND);
    tlast_d  = tvalid_d && (flit_idx_d == last_idx_d);
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
    tdata_d  = payload_wide[TDATA_WIDTH-1:0];
    if (tlast_d && (rem_d != 16'd0))
      tkeep_d = ~({TKEEP_WIDTH{1'b1}} << rem_d);
    else
      tkeep_d = '1;
  end

  // NOTE: state uses non-blocking assignments; the reset here is synchronous to clk.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      num_q      <= '0;
      gap_q      <= '0;
      last_idx_q <= '0;
      rem_q      <= '0;
      flit_idx_q <= '0;
      seq_q      <= '0;
      gap_cnt_q  <= '0;
      stop_req_q <= 1'b0;
      flit_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      tdata_q    <= '0;
      tkeep_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      gap_q      <= gap_d;
      last_idx_q <= last_idx_d;
      rem_q      <= rem_d;
      flit_idx_q <= flit_idx_d;
      seq_q      <= seq_d;
      gap_cnt_q  <= gap_cnt_d;
      stop_req_q <= stop_req_d;
      flit_cnt_q <= flit_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      tdata_q    <= tdata_d;
      tkeep_q    <= tkeep_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign out_stream_TDATA  = tdata_q;
  assign out_stream_TKEEP  = tkeep_q;
  assign out_stream_TVALID = tvalid_q;
  assign out_stream_TLAST  = tlast_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign sent_flit_count   = flit_cnt_q;
  assign sent_packet_count = pkt_cnt_q;

endmodule

// File: tb/tb_packet_generator.sv
// Bench for packet_generator: table of runs checked through a flit scoreboard,
// plus hand sequences for reset, ignored starts and mid-run reset.
module tb_packet_generator;
  localparam int DW = 512;
  localparam int KW = 64;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [15:0]   cfg_packet_bytes = '0;
  logic [31:0]   cfg_num_packets = '0;
  logic [15:0]   cfg_gap_cycles = '0;
  logic          tready = 1'b0;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic          tvalid, tlast, busy, done;
  logic [63:0]   flit_cnt, pkt_cnt;

  packet_generator #(.TDATA_WIDTH(DW), .TKEEP_WIDTH(KW)) dut (
    .clk               (clk),
    .aresetn           (aresetn),
    .start             (start),
    .stop              (stop),
    .cfg_packet_bytes  (cfg_packet_bytes),
    .cfg_num_packets   (cfg_num_packets),
    .cfg_gap_cycles    (cfg_gap_cycles),
    .out_stream_TDATA  (tdata),
    .out_stream_TKEEP  (tkeep),
    .out_stream_TVALID (tvalid),
    .out_stream_TREADY (tready),
    .out_stream_TLAST  (tlast),
    .busy              (busy),
    .done              (done),
    .sent_flit_count   (flit_cnt),
    .sent_packet_count (pkt_cnt)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } flit_t;

  typedef struct {
    int bytes;
    int num;
    int gap;
    bit rnd;
    int stop_mode;  // 0 none, 1 stop pulsed with start, 2 stop raised while flit 2 is presented
    int exp_flits;
    int exp_pkts;
  } vec_t;

  flit_t sb_q[$];
  vec_t  vecs[8];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic flit_t model(input int p, input int f, input int bytes);
    flit_t       m;
    int          nflits;
    int          rem;
    logic [63:0] w;
    nflits = (bytes + KW - 1) / KW;
    rem    = bytes % KW;
    w      = {p[31:0], f[31:0]};
    m.data = {8{w}};
    m.last = (f == nflits - 1);
    m.keep = '1;
    if (m.last && rem != 0) m.keep = m.keep >> (KW - rem);
    return m;
  endfunction

  task automatic push_expected(input vec_t v);
    int nflits;
    nflits = (v.bytes + KW - 1) / KW;
    for (int p = 0; p < v.exp_pkts; p++)
      for (int f = 0; f < nflits; f++)
        sb_q.push_back(model(p, f, v.bytes));
  endtask

  task automatic run_vec(input vec_t v);
    int            acc, low_run, last_acc;
    bit            between, finished, prev_v, prev_r;
    logic [DW-1:0] prev_d;
    logic [KW:0]   prev_kl;
    flit_t         e;
    acc = 0; low_run = 0; last_acc = -1;
    between = 0; finished = 0; prev_v = 0; prev_r = 0;
    prev_d = '0; prev_kl = '0;

    @(negedge clk);
    cfg_packet_bytes = 16'(v.bytes);
    cfg_num_packets  = 32'(v.num);
    cfg_gap_cycles   = 16'(v.gap);
    start = 1'b1;
    stop  = (v.stop_mode == 1);
    push_expected(v);
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("start_latency_tvalid", tvalid, 1);

    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (prev_v && !prev_r) begin
        check("stall_tvalid", tvalid, 1);
        check("stall_tdata", tdata, prev_d);
        check("stall_tkeep_tlast", {tkeep, tlast}, prev_kl);
      end
      if (done) begin
        check("done_latency", cyc - last_acc, 1);
        check("done_tvalid", tvalid, 0);
        check("flit_count", flit_cnt, v.exp_flits);
        check("packet_count", pkt_cnt, v.exp_pkts);
        check("accepted_flits", acc, v.exp_flits);
        check("scoreboard_empty", sb_q.size(), 0);
        finished = 1;
      end else if (tvalid) begin
        if (between) begin
          check("gap_length", low_run, v.gap);
          between = 0;
        end
        if (v.stop_mode == 2 && acc == 1) stop = 1'b1;
        tready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (tready) begin
          if (sb_q.size() == 0) begin
            check("scoreboard_underflow", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("tdata", tdata, e.data);
            check("tkeep", tkeep, e.keep);
            check("tlast", tlast, e.last);
          end
          acc++;
          last_acc = cyc;
          if (tlast) begin
            between = 1;
            low_run = 0;
          end
        end
      end else begin
        check("busy_in_gap", busy, 1);
        low_run++;
        tready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      prev_v  = tvalid;
      prev_r  = tready;
      prev_d  = tdata;
      prev_kl = {tkeep, tlast};
    end

    stop = 1'b0;
    if (!finished) begin
      check("run_timeout", 0, 1);
      sb_q.delete();
    end else begin
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("idle_busy", busy, 0);
      check("counts_hold", {flit_cnt, pkt_cnt}, {64'(v.exp_flits), 64'(v.exp_pkts)});
    end
    tready = 1'b0;
  endtask

  initial begin
    //          bytes num gap rnd stop flits pkts
    vecs[0] = '{   64,  3,  0, 0,  0,    3,   3};
    vecs[1] = '{  130,  1,  0, 0,  0,    3,   1};
    vecs[2] = '{  256,  1,  0, 1,  0,    4,   1};
    vecs[3] = '{   64,  2,  5, 0,  0,    2,   2};
    vecs[4] = '{  256,  0,  0, 0,  2,    4,   1};
    vecs[5] = '{    1,  2,  1, 1,  0,    2,   2};
    vecs[6] = '{  100,  0,  0, 0,  1,    2,   1};
    vecs[7] = '{  200,  3,  2, 1,  0,   12,   3};

    repeat (3) @(negedge clk);
    check("reset_tvalid", tvalid, 0);
    check("reset_tlast", tlast, 0);
    check("reset_tkeep", tkeep, 0);
    check("reset_tdata", tdata, 0);
    check("reset_busy_done", {busy, done}, 0);
    check("reset_counts", {flit_cnt, pkt_cnt}, 0);
    aresetn = 1'b1;

    // Zero-byte configuration must not launch a run.
    @(negedge clk);
    cfg_packet_bytes = 16'd0;
    cfg_num_packets  = 32'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero_bytes_busy", busy, 0);
    check("zero_bytes_tvalid", tvalid, 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Start while busy is ignored, then reset mid-run abandons the packet.
    @(negedge clk);
    cfg_packet_bytes = 16'd256;
    cfg_num_packets  = 32'd0;
    cfg_gap_cycles   = 16'd0;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    tready = 1'b1;
    check("mid_tvalid", tvalid, 1);
    @(negedge clk);
    cfg_packet_bytes = 16'd64;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_ignored_tlast", tlast, 0);
    check("busy_start_ignored_index", tdata[63:0], 64'd2);
    @(negedge clk);
    aresetn = 1'b0;
    @(negedge clk);
    check("midrun_reset_tvalid", tvalid, 0);
    check("midrun_reset_busy", busy, 0);
    check("midrun_reset_counts", {flit_cnt, pkt_cnt}, 0);
    aresetn = 1'b1;
    tready  = 1'b0;
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
